// File: rtl/sa_result_collector_if.sv
// Command encoding shared with the array, and the valid/ready result stream
// presented by sa_result_collector (master) to its consumer (slave).
package sa_collector_pkg;
   typedef enum logic [1:0] {
      CMD_IDLE   = 2'd0,
      CMD_LOAD   = 2'd1,
      CMD_STREAM = 2'd2,
      CMD_FLUSH  = 2'd3
   } command_t;
endpackage

interface sa_result_collector_if #(
   parameter int SA_SIZE         = 8,
   parameter int ACTIVATION_SIZE = 8
);
   logic                       res_valid;
   logic                       res_ready;
   logic [ACTIVATION_SIZE-1:0] res_data [SA_SIZE];

   modport master (output res_valid, output res_data, input res_ready);
   modport slave  (input res_valid, input res_data, output res_ready);
endinterface

// File: rtl/sa_result_collector.sv
// Receive end of the systolic array's skewed stream: deskews column outputs into
// aligned vectors, buffers them in a FIFO and grants issue credits. Optional ReLU: SA_COLLECT_RELU_EN.
module sa_result_collector
   import sa_collector_pkg::*;
#(
   parameter int SA_SIZE         = 8,
   parameter int ACTIVATION_SIZE = 8,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic                             clk,
   input  logic                             resetn,
   input  command_t                         cmd,
   input  logic                             issue_valid,
   output logic                             issue_ready,
   input  logic [ACTIVATION_SIZE-1:0]       sa_outputs [SA_SIZE],
   sa_result_collector_if.master            res,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
   output logic                             busy,
   output logic                             overflow_err
);
   localparam int TAG_W = 2*SA_SIZE - 1;
   localparam int CW    = $clog2(FIFO_DEPTH+1);
   localparam int AW    = $clog2(FIFO_DEPTH);

   typedef logic [SA_SIZE-1:0][ACTIVATION_SIZE-1:0] vec_t;

   logic             adv;
   logic             issue_acc;
   logic             complete;
   logic             push;
   logic             pop;
   logic             valid_int;
   logic [TAG_W-2:0] tag_q;
   logic [TAG_W-1:0] tags_now;
   logic [CW-1:0]    inflight;
   logic [CW:0]      credit_used;
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   vec_t             aligned;
   vec_t             mem [FIFO_DEPTH];

   function automatic logic [ACTIVATION_SIZE-1:0] relu(input logic [ACTIVATION_SIZE-1:0] x);
`ifdef SA_COLLECT_RELU_EN
      return x[ACTIVATION_SIZE-1] ? '0 : x;
`else
      return x;
`endif
   endfunction

   assign adv         = (cmd == CMD_STREAM);
   assign credit_used = {1'b0, inflight} + {1'b0, fifo_count};
   assign issue_ready = credit_used < (CW+1)'(FIFO_DEPTH);
   assign issue_acc   = adv && issue_valid && issue_ready;

   // tags_now[k] set: a vector was issued k advance steps ago (k=0 is this step)
   assign tags_now  = {tag_q, issue_acc};
   assign complete  = adv && tags_now[TAG_W-1];
   assign valid_int = (fifo_count != '0);
   assign pop       = valid_int && res.res_ready;
   assign push      = complete && ((fifo_count != CW'(FIFO_DEPTH)) || pop);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tag_q        <= '0;
         inflight     <= '0;
         overflow_err <= 1'b0;
      end else begin
         if (adv) begin
            tag_q    <= tags_now[TAG_W-2:0];
            inflight <= inflight + CW'(issue_acc) - CW'(complete);
         end
         if (adv && issue_valid && !issue_ready)
            overflow_err <= 1'b1;
      end
   end

   // Column c is sampled on its arrival step and delayed so all columns line up
   // on the completion step; the last column needs no delay.
   for (genvar c = 0; c < SA_SIZE; c++) begin : g_col
      logic [ACTIVATION_SIZE-1:0] cap;
      assign cap = tags_now[SA_SIZE-1+c] ? relu(sa_outputs[c]) : '0;

      if (c < SA_SIZE-1) begin : g_dly
         localparam int DLEN = SA_SIZE - 1 - c;
         logic [ACTIVATION_SIZE-1:0] dly [DLEN];

         always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
               for (int i = 0; i < DLEN; i++) dly[i] <= '0;
            end else if (adv) begin
               dly[0] <= cap;
               for (int i = 1; i < DLEN; i++) dly[i] <= dly[i-1];
            end
         end

         assign aligned[c] = dly[DLEN-1];
      end else begin : g_direct
         assign aligned[c] = cap;
      end

      assign res.res_data[c] = mem[rd_ptr][c];
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= aligned;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         fifo_count <= fifo_count + CW'(push) - CW'(pop);
      end
   end

   assign res.res_valid = valid_int;
   assign busy          = (inflight != '0) || valid_int;

endmodule

// File: tb/tb_sa_result_collector.sv
// Bench for sa_result_collector: table-driven single-vector run, hand-written corner
// sequences and randomized traffic checked against a step-indexed queue model.
module tb_sa_result_collector;
   import sa_collector_pkg::*;

   localparam int N = 4;
   localparam int W = 8;
   localparam int D = 4;

   logic       clk;
   logic       resetn;
   command_t   cmd;
   logic       issue_valid;
   logic       issue_ready;
   logic [W-1:0] sa_outputs [N];
   logic [2:0] fifo_count;
   logic       busy;
   logic       overflow_err;

   sa_result_collector_if #(.SA_SIZE(N), .ACTIVATION_SIZE(W)) rif ();

   sa_result_collector #(.SA_SIZE(N), .ACTIVATION_SIZE(W), .FIFO_DEPTH(D)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .cmd          (cmd),
      .issue_valid  (issue_valid),
      .issue_ready  (issue_ready),
      .sa_outputs   (sa_outputs),
      .res          (rif),
      .fifo_count   (fifo_count),
      .busy         (busy),
      .overflow_err (overflow_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int pass_cnt  = 0;
   int total_cnt = 0;

   logic [31:0] dut_data;
   always_comb begin
      dut_data = '0;
      for (int c = 0; c < N; c++) dut_data[8*c +: 8] = rif.res_data[c];
   end

   // Reference model: advance-step counter, issue steps of in-flight vectors,
   // per-step record of sa_outputs, and a queue of expected aligned vectors.
   int          m_step;
   int          m_issued [$];
   logic [31:0] m_q [$];
   logic [31:0] m_hist [int];
   logic        m_ovf;

   function automatic logic [7:0] m_relu(input logic [7:0] x);
`ifdef SA_COLLECT_RELU_EN
      return x[7] ? 8'h00 : x;
`else
      return x;
`endif
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
   endtask

   task automatic model_clear();
      m_step = 0;
      m_issued.delete();
      m_q.delete();
      m_hist.delete();
      m_ovf = 1'b0;
   endtask

   task automatic cyc(input command_t cm, input logic iv, input logic [31:0] o, input logic rr);
      logic        m_ready;
      logic [31:0] v;
      logic [31:0] h;
      int          s;
      m_ready = (m_issued.size() + m_q.size()) < D;
      cmd = cm;
      issue_valid = iv;
      rif.res_ready = rr;
      for (int k = 0; k < N; k++) sa_outputs[k] = o[8*k +: 8];
      if (m_q.size() > 0 && rr) v = m_q.pop_front();
      if (cm == CMD_STREAM) begin
         m_hist[m_step] = o;
         if (iv) begin
            if (m_ready) m_issued.push_back(m_step);
            else m_ovf = 1'b1;
         end
         if (m_issued.size() > 0 && m_issued[0] + 2*N - 2 == m_step) begin
            s = m_issued.pop_front();
            for (int k = 0; k < N; k++) begin
               h = m_hist[s + N - 1 + k];
               v[8*k +: 8] = m_relu(h[8*k +: 8]);
            end
            m_q.push_back(v);
         end
         m_step++;
      end
      @(posedge clk);
      #1;
      chk("m_res_valid", 32'(rif.res_valid), 32'(m_q.size() != 0));
      chk("m_fifo_count", 32'(fifo_count), 32'(m_q.size()));
      chk("m_issue_ready", 32'(issue_ready), 32'((m_issued.size() + m_q.size()) < D));
      chk("m_busy", 32'(busy), 32'(m_issued.size() != 0 || m_q.size() != 0));
      chk("m_overflow_err", 32'(overflow_err), 32'(m_ovf));
      if (m_q.size() > 0) chk("m_res_data", dut_data, m_q[0]);
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      cmd = CMD_IDLE;
      issue_valid = 1'b0;
      rif.res_ready = 1'b0;
      for (int k = 0; k < N; k++) sa_outputs[k] = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;
      @(posedge clk);
      #1;
      model_clear();
   endtask

   typedef struct {
      command_t    cmd;
      logic        iv;
      logic [31:0] outs;
      logic        rr;
      logic        exp_valid;
      logic [2:0]  exp_cnt;
      logic        exp_busy;
      logic        exp_ready;
      logic        chk_data;
      logic [31:0] exp_data;
   } row_t;

   row_t tbl [9];
   int   npop;
   int   r;
   logic [31:0] relu_exp;
   command_t    rc;

   initial begin
      tbl[0] = '{CMD_STREAM, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 32'h0};
      tbl[1] = '{CMD_STREAM, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 32'h0};
      tbl[2] = '{CMD_STREAM, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 32'h0};
      tbl[3] = '{CMD_STREAM, 1'b0, 32'hFFFFFF10, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 32'h0};
      tbl[4] = '{CMD_STREAM, 1'b0, 32'hFFFF11FF, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 32'h0};
      tbl[5] = '{CMD_STREAM, 1'b0, 32'hFF12FFFF, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 32'h0};
      tbl[6] = '{CMD_STREAM, 1'b0, 32'h13FFFFFF, 1'b0, 1'b1, 3'd1, 1'b1, 1'b1, 1'b1, 32'h13121110};
      tbl[7] = '{CMD_IDLE,   1'b0, 32'hFFFFFFFF, 1'b0, 1'b1, 3'd1, 1'b1, 1'b1, 1'b1, 32'h13121110};
      tbl[8] = '{CMD_IDLE,   1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 32'h0};

      resetn = 1'b1;
      cmd = CMD_IDLE;
      issue_valid = 1'b0;
      rif.res_ready = 1'b0;
      for (int k = 0; k < N; k++) sa_outputs[k] = '0;
      #2;
      do_reset();

      chk("rst_res_valid", 32'(rif.res_valid), 32'd0);
      chk("rst_res_data", dut_data, 32'd0);
      chk("rst_fifo_count", 32'(fifo_count), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_overflow", 32'(overflow_err), 32'd0);
      chk("rst_issue_ready", 32'(issue_ready), 32'd1);

      // single vector, table driven
      for (int i = 0; i < 9; i++) begin
         cyc(tbl[i].cmd, tbl[i].iv, tbl[i].outs, tbl[i].rr);
         chk("tbl_valid", 32'(rif.res_valid), 32'(tbl[i].exp_valid));
         chk("tbl_count", 32'(fifo_count), 32'(tbl[i].exp_cnt));
         chk("tbl_busy", 32'(busy), 32'(tbl[i].exp_busy));
         chk("tbl_ready", 32'(issue_ready), 32'(tbl[i].exp_ready));
         if (tbl[i].chk_data) chk("tbl_data", dut_data, tbl[i].exp_data);
      end

      // stall insertion: idle cycles between steps 2 and 3 carry junk that must not be captured
      do_reset();
      cyc(CMD_STREAM, 1'b1, 32'hFFFFFFFF, 1'b0);
      cyc(CMD_STREAM, 1'b0, 32'hFFFFFFFF, 1'b0);
      cyc(CMD_STREAM, 1'b0, 32'hFFFFFFFF, 1'b0);
      repeat (3) cyc(CMD_IDLE, 1'b0, 32'hAAAAAAAA, 1'b0);
      cyc(CMD_STREAM, 1'b0, 32'hFFFFFF10, 1'b0);
      cyc(CMD_STREAM, 1'b0, 32'hFFFF11FF, 1'b0);
      cyc(CMD_STREAM, 1'b0, 32'hFF12FFFF, 1'b0);
      chk("stall_not_early", 32'(rif.res_valid), 32'd0);
      cyc(CMD_STREAM, 1'b0, 32'h13FFFFFF, 1'b0);
      chk("stall_valid", 32'(rif.res_valid), 32'd1);
      chk("stall_data", dut_data, 32'h13121110);
      cyc(CMD_IDLE, 1'b0, 32'hFFFFFFFF, 1'b1);
      chk("stall_popped", 32'(fifo_count), 32'd0);

      // credit exhaustion and backpressure
      do_reset();
      for (int i = 0; i < 4; i++) cyc(CMD_STREAM, 1'b1, $urandom, 1'b0);
      chk("credit_ready_low", 32'(issue_ready), 32'd0);
      cyc(CMD_STREAM, 1'b1, $urandom, 1'b0);
      chk("overflow_set", 32'(overflow_err), 32'd1);
      repeat (6) cyc(CMD_STREAM, 1'b0, $urandom, 1'b0);
      chk("credit_full_count", 32'(fifo_count), 32'd4);
      npop = 0;
      for (int i = 0; i < 6; i++) begin
         if (rif.res_valid) npop++;
         cyc(CMD_IDLE, 1'b0, $urandom, 1'b1);
      end
      chk("credit_pop_total", 32'(npop), 32'd4);
      chk("credit_drained", 32'(fifo_count), 32'd0);

      // concurrent push/pop with a feeder that honours credit
      do_reset();
      for (int i = 0; i < 40; i++) begin
         cyc(CMD_STREAM, 1'((m_issued.size() + m_q.size()) < D), $urandom, 1'b1);
         chk("concurrent_count_le1", 32'(fifo_count <= 3'd1), 32'd1);
      end
      chk("concurrent_no_overflow", 32'(overflow_err), 32'd0);

      // async reset with two vectors in flight and one buffered
      do_reset();
      cyc(CMD_STREAM, 1'b1, $urandom, 1'b0);
      repeat (3) cyc(CMD_STREAM, 1'b0, $urandom, 1'b0);
      cyc(CMD_STREAM, 1'b1, $urandom, 1'b0);
      cyc(CMD_STREAM, 1'b1, $urandom, 1'b0);
      cyc(CMD_STREAM, 1'b0, $urandom, 1'b0);
      chk("arst_pre_count", 32'(fifo_count), 32'd1);
      chk("arst_pre_ready", 32'(issue_ready), 32'd1);
      #2;
      resetn = 1'b0;
      #1;
      chk("arst_valid", 32'(rif.res_valid), 32'd0);
      chk("arst_count", 32'(fifo_count), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_ready", 32'(issue_ready), 32'd1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;
      @(posedge clk);
      #1;
      model_clear();
      repeat (12) cyc(CMD_STREAM, 1'b0, $urandom, 1'b1);
      chk("arst_no_stale", 32'(rif.res_valid), 32'd0);

      // signed capture: ReLU clamps negative elements when enabled
      do_reset();
      cyc(CMD_STREAM, 1'b1, 32'h01FF7F80, 1'b0);
      repeat (6) cyc(CMD_STREAM, 1'b0, 32'h01FF7F80, 1'b0);
`ifdef SA_COLLECT_RELU_EN
      relu_exp = 32'h01007F00;
`else
      relu_exp = 32'h01FF7F80;
`endif
      chk("relu_valid", 32'(rif.res_valid), 32'd1);
      chk("relu_data", dut_data, relu_exp);

      // randomized traffic against the model
      do_reset();
      for (int i = 0; i < 500; i++) begin
         r = $urandom_range(0, 9);
         rc = (r < 7) ? CMD_STREAM : ((r == 7) ? CMD_IDLE : CMD_LOAD);
         cyc(rc, 1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 2) != 0));
      end
      repeat (20) cyc(CMD_STREAM, 1'b0, $urandom, 1'b1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
